// File: rtl/tl45_wb_arbiter.sv
// tl45_wb_arbiter: two-master, one-slave pipelined Wishbone arbiter for the TL45 system bus.
//
// Master 0 is the memory stage, master 1 the caching instruction prefetch. A master holds the
// grant for as long as it keeps CYC high. When both request at once, the master that was not
// granted last wins. The slave-side mux is steered only by the registered state, so there is
// no combinational path from a request to the bus.
//
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_mX_cyc/stb/we        master X cycle, strobe, write enable
//   i_mX_addr/data/sel     master X word address, write data, byte select
//   o_mX_ack/stall/err     master X responses (stall=1, ack=err=0 when not granted)
//   o_mX_data              master X read data (0 when not granted)
//   o_wb_*                 slave-side request signals
//   i_wb_ack/stall/err     slave responses
//   i_wb_data              slave read data
//   o_grant                one-hot grant {m1, m0}, 00 when idle
//
// Optional feature, enabled by defining WB_ARB_TIMEOUT_EN: an 8-bit bus-timeout counter that
// errors the granted master after TIMEOUT cycles without a slave response and then holds the
// bus idle (ABORT) until that master drops CYC.

module tl45_wb_arbiter #(
    parameter int unsigned AW      = 30,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_reset,
    // Master 0 (memory stage)
    input  logic          i_m0_cyc,
    input  logic          i_m0_stb,
    input  logic          i_m0_we,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_data,
    input  logic [3:0]    i_m0_sel,
    output logic          o_m0_ack,
    output logic          o_m0_stall,
    output logic          o_m0_err,
    output logic [DW-1:0] o_m0_data,
    // Master 1 (instruction prefetch)
    input  logic          i_m1_cyc,
    input  logic          i_m1_stb,
    input  logic          i_m1_we,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_data,
    input  logic [3:0]    i_m1_sel,
    output logic          o_m1_ack,
    output logic          o_m1_stall,
    output logic          o_m1_err,
    output logic [DW-1:0] o_m1_data,
    // Slave side
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [DW-1:0] o_wb_data,
    output logic [3:0]    o_wb_sel,
    input  logic          i_wb_ack,
    input  logic          i_wb_stall,
    input  logic          i_wb_err,
    input  logic [DW-1:0] i_wb_data,
    output logic [1:0]    o_grant
);

    typedef enum logic [1:0] {
        StIdle,
        StGrantM0,
        StGrantM1
`ifdef WB_ARB_TIMEOUT_EN
        , StAbort
`endif
    } state_e;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;   // 0: m0 was granted last, 1: m1
    logic   granted_cyc;                  // CYC of the currently granted master
    logic   timeout_hit;

    localparam logic [7:0] TimeoutCount = 8'(TIMEOUT);

    // Arbitration rule shared by IDLE and by the release edge of a grant.
    function automatic state_e arbitrate(input logic req0, input logic req1, input logic last);
        state_e res;
        res = StIdle;
        if (req0 && req1) begin
            res = last ? StGrantM0 : StGrantM1;
        end else if (req0) begin
            res = StGrantM0;
        end else if (req1) begin
            res = StGrantM1;
        end
        return res;
    endfunction

    always_comb begin
        granted_cyc = 1'b0;
        if (state_q == StGrantM0) begin
            granted_cyc = i_m0_cyc;
        end else if (state_q == StGrantM1) begin
            granted_cyc = i_m1_cyc;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] timer_q, timer_d;
    logic       abort_m1_q;   // which master owned the bus when the abort started

    // A response in the same cycle as the limit wins over the timeout.
    assign timeout_hit = granted_cyc && (timer_q == TimeoutCount) && !i_wb_ack && !i_wb_err;

    always_comb begin
        timer_d = timer_q;
        if ((state_d != state_q) || i_wb_ack || i_wb_err) begin
            timer_d = 8'd0;
        end else if (granted_cyc) begin
            timer_d = timer_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            timer_q    <= 8'd0;
            abort_m1_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            if (state_q != StAbort) begin
                abort_m1_q <= (state_q == StGrantM1);
            end
        end
    end
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TimeoutCount;
`endif

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            StIdle: begin
                state_d = arbitrate(i_m0_cyc, i_m1_cyc, last_grant_q);
            end
            StGrantM0: begin
                if (!i_m0_cyc) begin
                    last_grant_d = 1'b0;
                    state_d      = arbitrate(1'b0, i_m1_cyc, 1'b0);
`ifdef WB_ARB_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_d = StAbort;
`endif
                end
            end
            StGrantM1: begin
                if (!i_m1_cyc) begin
                    last_grant_d = 1'b1;
                    state_d      = arbitrate(i_m0_cyc, 1'b0, 1'b1);
`ifdef WB_ARB_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_d = StAbort;
`endif
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            StAbort: begin
                if (abort_m1_q ? !i_m1_cyc : !i_m0_cyc) begin
                    last_grant_d = abort_m1_q;
                    state_d      = arbitrate(i_m0_cyc && abort_m1_q, i_m1_cyc && !abort_m1_q,
                                             abort_m1_q);
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Bus mux and response steering, driven only by the registered state.
    always_comb begin
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        o_wb_we    = 1'b0;
        o_wb_addr  = '0;
        o_wb_data  = '0;
        o_wb_sel   = 4'h0;
        o_m0_ack   = 1'b0;
        o_m0_stall = 1'b1;
        o_m0_err   = 1'b0;
        o_m0_data  = '0;
        o_m1_ack   = 1'b0;
        o_m1_stall = 1'b1;
        o_m1_err   = 1'b0;
        o_m1_data  = '0;
        case (state_q)
            StGrantM0: begin
                o_wb_cyc   = i_m0_cyc;
                o_wb_stb   = i_m0_cyc & i_m0_stb;
                o_wb_we    = i_m0_we;
                o_wb_addr  = i_m0_addr;
                o_wb_data  = i_m0_data;
                o_wb_sel   = i_m0_sel;
                o_m0_ack   = i_wb_ack;
                o_m0_stall = i_wb_stall;
                o_m0_err   = i_wb_err | timeout_hit;
                o_m0_data  = i_wb_data;
            end
            StGrantM1: begin
                o_wb_cyc   = i_m1_cyc;
                o_wb_stb   = i_m1_cyc & i_m1_stb;
                o_wb_we    = i_m1_we;
                o_wb_addr  = i_m1_addr;
                o_wb_data  = i_m1_data;
                o_wb_sel   = i_m1_sel;
                o_m1_ack   = i_wb_ack;
                o_m1_stall = i_wb_stall;
                o_m1_err   = i_wb_err | timeout_hit;
                o_m1_data  = i_wb_data;
            end
            default: begin
                // IDLE and ABORT keep the defaults: bus quiet, masters stalled.
            end
        endcase
    end

    assign o_grant = {state_q == StGrantM1, state_q == StGrantM0};

endmodule

// File: tb/tb_tl45_wb_arbiter.sv
// Self-checking bench for tl45_wb_arbiter (default build, no bus timeout).
// A transaction-level model tracks which master owns the bus; every cycle the bench derives
// the expected bus mux and master responses from it, plus directed checks for key scenarios.

module tb_tl45_wb_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [3:0]    m0_sel, m1_sel;
    logic          m0_ack, m0_stall, m0_err, m1_ack, m1_stall, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_wdata;
    logic [3:0]    wb_sel;
    logic          wb_ack, wb_stall, wb_err;
    logic [DW-1:0] wb_rdata;
    logic [1:0]    grant;

    always #5 clk = ~clk;

    tl45_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(255)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_m0_cyc   (m0_cyc),
        .i_m0_stb   (m0_stb),
        .i_m0_we    (m0_we),
        .i_m0_addr  (m0_addr),
        .i_m0_data  (m0_wdata),
        .i_m0_sel   (m0_sel),
        .o_m0_ack   (m0_ack),
        .o_m0_stall (m0_stall),
        .o_m0_err   (m0_err),
        .o_m0_data  (m0_rdata),
        .i_m1_cyc   (m1_cyc),
        .i_m1_stb   (m1_stb),
        .i_m1_we    (m1_we),
        .i_m1_addr  (m1_addr),
        .i_m1_data  (m1_wdata),
        .i_m1_sel   (m1_sel),
        .o_m1_ack   (m1_ack),
        .o_m1_stall (m1_stall),
        .o_m1_err   (m1_err),
        .o_m1_data  (m1_rdata),
        .o_wb_cyc   (wb_cyc),
        .o_wb_stb   (wb_stb),
        .o_wb_we    (wb_we),
        .o_wb_addr  (wb_addr),
        .o_wb_data  (wb_wdata),
        .i_wb_ack   (wb_ack),
        .i_wb_stall (wb_stall),
        .i_wb_err   (wb_err),
        .i_wb_data  (wb_rdata),
        .o_wb_sel   (wb_sel),
        .o_grant    (grant)
    );

    int checks = 0;
    int errors = 0;
    int owner  = 0;      // model: 0 bus free, 1 m0 owns it, 2 m1 owns it
    bit last   = 1'b0;   // model: index of the master granted most recently

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Both requesting: the one that was not granted last wins.
    function automatic int pick(bit r0, bit r1, bit lst);
        if (r0 && r1) return lst ? 1 : 2;
        if (r0) return 1;
        if (r1) return 2;
        return 0;
    endfunction

    task automatic check_generic();
        logic [1:0]  eg;
        logic [68:0] ebus;
        logic [34:0] er0, er1;
        eg   = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
        ebus = '0;
        er0  = {1'b0, 1'b1, 1'b0, 32'h0};
        er1  = {1'b0, 1'b1, 1'b0, 32'h0};
        if (owner == 1) begin
            ebus = {m0_cyc, m0_cyc & m0_stb, m0_we, m0_addr, m0_wdata, m0_sel};
            er0  = {wb_ack, wb_stall, wb_err, wb_rdata};
        end else if (owner == 2) begin
            ebus = {m1_cyc, m1_cyc & m1_stb, m1_we, m1_addr, m1_wdata, m1_sel};
            er1  = {wb_ack, wb_stall, wb_err, wb_rdata};
        end
        chk("grant", grant, eg);
        chk("bus", {wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel}, ebus);
        chk("m0_resp", {m0_ack, m0_stall, m0_err, m0_rdata}, er0);
        chk("m1_resp", {m1_ack, m1_stall, m1_err, m1_rdata}, er1);
    endtask

    // Inputs are set just after a rising edge; outputs are sampled at the falling edge.
    task automatic settle();
        #4;
        check_generic();
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            owner = 0;
            last  = 1'b0;
        end else if (owner == 0) begin
            owner = pick(m0_cyc, m1_cyc, last);
        end else if (owner == 1 && !m0_cyc) begin
            last  = 1'b0;
            owner = pick(m0_cyc, m1_cyc, last);
        end else if (owner == 2 && !m1_cyc) begin
            last  = 1'b1;
            owner = pick(m0_cyc, m1_cyc, last);
        end
        #1;
    endtask

    initial begin
        int         zeros;
        int         n0, n1;
        bit         acked;
        logic [1:0] prev_g, last_new;

        rst = 1'b1;
        {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; m0_sel = '0; m1_sel = '0;
        wb_ack = 1'b0; wb_stall = 1'b0; wb_err = 1'b0; wb_rdata = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        settle();
        chk("rst_grant", grant, 2'b00);
        chk("rst_m0_stall", m0_stall, 1'b1);
        chk("rst_m1_stall", m1_stall, 1'b1);
        chk("rst_acks", {m0_ack, m0_err, m1_ack, m1_err}, 4'b0000);
        tick();

        // Reset in the middle of an m1 bus cycle
        m1_cyc = 1'b1;
        settle();
        tick();
        settle();
        chk("midrst_pre_grant", grant, 2'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("midrst_grant", grant, 2'b00);
        chk("midrst_cyc", wb_cyc, 1'b0);
        chk("midrst_m1_stall", m1_stall, 1'b1);
        tick();
        m1_cyc = 1'b0;
        settle();
        tick();
        rst = 1'b1;
        settle();
        tick();
        rst = 1'b0;

        // Single master: m1 reads 0x100, slave acks two clocks later
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_addr = 30'h100;
        settle();
        chk("single_idle_stb", wb_stb, 1'b0);
        tick();
        settle();
        chk("single_grant", grant, 2'b10);
        chk("single_addr", wb_addr, 30'h100);
        chk("single_stb", wb_stb, 1'b1);
        tick();
        m1_stb = 1'b0;
        settle();
        chk("single_m0_ack_wait", m0_ack, 1'b0);
        tick();
        wb_ack = 1'b1; wb_rdata = 32'hDEADBEEF;
        settle();
        chk("single_m1_ack", m1_ack, 1'b1);
        chk("single_m1_data", m1_rdata, 32'hDEADBEEF);
        chk("single_m0_ack", m0_ack, 1'b0);
        tick();
        wb_ack = 1'b0; wb_rdata = '0; m1_cyc = 1'b0;
        settle();
        tick();

        // Simultaneous request after reset: m1 first, then m0 with a single idle bus cycle
        rst = 1'b1;
        settle();
        tick();
        rst = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        settle();
        tick();
        settle();
        chk("sim_first", grant, 2'b10);
        tick();
        m1_cyc = 1'b0; m1_stb = 1'b0;
        zeros = 0;
        settle();
        if (!wb_cyc) zeros++;
        tick();
        settle();
        if (!wb_cyc) zeros++;
        chk("sim_second", grant, 2'b01);
        chk("sim_gap", zeros, 1);
        tick();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        settle();
        tick();

        // Alternation: both keep requesting; the owner drops CYC for one cycle after its ack
        n0 = 0; n1 = 0; acked = 1'b0; prev_g = 2'b00; last_new = 2'b00;
        for (int i = 0; i < 60 && !(n0 >= 4 && n1 >= 4); i++) begin
            m0_cyc = !(owner == 1 && acked);
            m1_cyc = !(owner == 2 && acked);
            m0_stb = m0_cyc;
            m1_stb = m1_cyc;
            wb_ack = (owner != 0) && !acked;
            settle();
            if (grant != 2'b00 && grant != prev_g) begin
                if (last_new != 2'b00) begin
                    chk("alt_grant", grant, (last_new == 2'b01) ? 2'b10 : 2'b01);
                end
                last_new = grant;
                if (grant == 2'b01) n0++;
                if (grant == 2'b10) n1++;
            end
            prev_g = grant;
            tick();
            acked = wb_ack;
        end
        chk("alt_count", {n0 >= 4, n1 >= 4}, 2'b11);
        m0_cyc = 1'b0; m1_cyc = 1'b0; m0_stb = 1'b0; m1_stb = 1'b0; wb_ack = 1'b0;
        settle();
        tick();
        settle();
        tick();

        // Stall isolation: m0 write held by slave stall while m1 waits
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_addr = 30'h40;
        m0_wdata = 32'h12345678; m0_sel = 4'hF;
        settle();
        tick();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 30'h2AAAAAA;
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_stb", wb_stb, 1'b1);
            chk("stall_addr", wb_addr, 30'h40);
            chk("stall_m1", m1_stall, 1'b1);
            chk("stall_m0", m0_stall, 1'b1);
            tick();
        end
        wb_stall = 1'b0;
        settle();
        chk("stall_wdata", wb_wdata, 32'h12345678);
        tick();
        m0_stb = 1'b0; wb_ack = 1'b1;
        settle();
        chk("stall_m0_ack", m0_ack, 1'b1);
        chk("stall_m1_ack", m1_ack, 1'b0);
        tick();
        wb_ack = 1'b0; m0_cyc = 1'b0; m0_we = 1'b0;
        settle();
        tick();
        settle();
        chk("stall_handover", grant, 2'b10);
        chk("stall_m1_addr", wb_addr, 30'h2AAAAAA);
        tick();
        m1_cyc = 1'b0; m1_stb = 1'b0;
        settle();
        tick();

        // Randomized traffic, including stray slave responses and occasional resets
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 99) < 3);
            m0_cyc   = ($urandom_range(0, 9) < 7);
            m1_cyc   = ($urandom_range(0, 9) < 7);
            m0_stb   = 1'($urandom);
            m1_stb   = 1'($urandom);
            m0_we    = 1'($urandom);
            m1_we    = 1'($urandom);
            m0_addr  = 30'($urandom);
            m1_addr  = 30'($urandom);
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            m0_sel   = 4'($urandom);
            m1_sel   = 4'($urandom);
            wb_ack   = 1'($urandom);
            wb_stall = 1'($urandom);
            wb_err   = ($urandom_range(0, 9) == 0);
            wb_rdata = $urandom;
            settle();
            tick();
        end
        rst = 1'b0;
        settle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
